aes128_iter_core: RTL

- Sequential AES-128 encryption core with valid/ready handshakes on both input and output.
- Performs ROUNDS_PER_CYCLE AES rounds per clock, so one parameter trades area against latency.
- At ROUNDS_PER_CYCLE=10 it is fully unrolled, with a single register stage.
- Sits between the block-cipher mode logic upstream and the ciphertext sink downstream; processes one block at a time.

---
 rtl/aes128_iter_core.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encryption core.
// Runs ROUNDS_PER_CYCLE rounds per clock (1, 2, 5 or 10; 10 is fully unrolled).
// Block bytes are in FIPS-197 order: byte 0 in bits [127:120].
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    plaintext+key handshake (accepted only in IDLE)
//   plaintext, key         128-bit input block and cipher key
//   out_valid / out_ready  ciphertext handshake (held in DONE until taken)
//   cipher_text            result block, held until the next result
//   busy                   high while a block is in RUN or DONE
//   keyout                 round-10 key, only when AES_KEYOUT_EN is defined
//
// Optional feature macro: AES_KEYOUT_EN (adds the keyout port and register).
module aes128_iter_core #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned NUM_ROUNDS       = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cipher_text,
    output logic         busy
`ifdef AES_KEYOUT_EN
    ,
    output logic [127:0] keyout
`endif
);

    localparam int unsigned RPC = ROUNDS_PER_CYCLE;

    // Reject unsupported configurations at elaboration.
    generate
        if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10) || NUM_ROUNDS != 10) begin : g_cfg_err
            $fatal(1, "aes128_iter_core: illegal ROUNDS_PER_CYCLE or NUM_ROUNDS");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[3'(i)]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box: multiplicative inverse as x^254, then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(x3, x3);
        x12  = gf_mul(x12, x12);
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One step of the key schedule: words w0..w3 of the previous round key.
    function automatic logic [127:0] key_next(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, rot, tmp;
        w0  = rk[127:96];
        w1  = rk[95:64];
        w2  = rk[63:32];
        w3  = rk[31:0];
        rot = {w3[23:0], w3[31:24]};
        tmp = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        w0  = w0 ^ tmp;
        w1  = w1 ^ w0;
        w2  = w2 ^ w1;
        w3  = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // SubBytes, ShiftRows, MixColumns (skipped in the final round), AddRoundKey.
    function automatic logic [127:0] round_fn(input logic [127:0] st, input logic [127:0] rk,
                                              input logic last);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) begin
            s[4'(k)] = sbox(st[7'(127 - 8 * k) -: 8]);
        end
        // Byte index is row + 4*col; row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[4'(r + 4 * c)] = s[4'(r + 4 * ((c + r) % 4))];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = t[4'(4 * c)];
            a1 = t[4'(4 * c + 1)];
            a2 = t[4'(4 * c + 2)];
            a3 = t[4'(4 * c + 3)];
            if (last) begin
                u[4'(4 * c)]     = a0;
                u[4'(4 * c + 1)] = a1;
                u[4'(4 * c + 2)] = a2;
                u[4'(4 * c + 3)] = a3;
            end else begin
                u[4'(4 * c)]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                u[4'(4 * c + 1)] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                u[4'(4 * c + 2)] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                u[4'(4 * c + 3)] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[7'(127 - 8 * k) -: 8] = u[4'(k)];
        end
        return o ^ rk;
    endfunction

    state_t       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] ct_d;
    logic         in_ready_d, out_valid_d, busy_d;
    logic [127:0] stg_st, stg_rk;
    logic [3:0]   stg_rnd;
`ifdef AES_KEYOUT_EN
    logic [127:0] ko_d;
`endif

    // Unrolled chain of RPC rounds starting at round rnd_q.
    always_comb begin : round_chain
        stg_st  = st_q;
        stg_rk  = rk_q;
        stg_rnd = rnd_q;
        for (int unsigned i = 0; i < RPC; i++) begin
            stg_rnd = rnd_q + 4'(i);
            stg_rk  = key_next(stg_rk, rcon_of(stg_rnd));
            stg_st  = round_fn(stg_st, stg_rk, stg_rnd == 4'(NUM_ROUNDS));
        end
    end

    // Next-state and next-output logic.
    always_comb begin : next_state
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        ct_d    = cipher_text;
`ifdef AES_KEYOUT_EN
        ko_d    = keyout;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    st_d    = plaintext ^ key;
                    rk_d    = key;
                    rnd_d   = 4'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                st_d  = stg_st;
                rk_d  = stg_rk;
                rnd_d = rnd_q + 4'(RPC);
                if (stg_rnd == 4'(NUM_ROUNDS)) begin
                    state_d = DONE;
                    ct_d    = stg_st;
`ifdef AES_KEYOUT_EN
                    ko_d    = stg_rk;
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            rnd_q       <= '0;
            cipher_text <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
`ifdef AES_KEYOUT_EN
            keyout      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            rnd_q       <= rnd_d;
            cipher_text <= ct_d;
            in_ready    <= in_ready_d;
            out_valid   <= out_valid_d;
            busy        <= busy_d;
`ifdef AES_KEYOUT_EN
            keyout      <= ko_d;
`endif
        end
    end

endmodule
